// File: rtl/md_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: operation codes, FSM state encodings, valid/invalid flags,
// and small helpers that decode the operation code.
package md_seq_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  // Operation codes presented on md_op.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  localparam logic VALID   = 1'b1;
  localparam logic INVALID = 1'b0;

  // Divide ops have the upper op-code bit set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (mult, div) have the lower op-code bit clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide
// sequencer.
// Signals:
//   start, md_op, regaData, regbData, cancel : request side (driven by master)
//   busy, stall, done, whi, wlo, wHiData, wLoData : status/result (driven by slave)
interface md_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] regaData;
  logic [WIDTH-1:0] regbData;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic             whi;
  logic             wlo;
  logic [WIDTH-1:0] wHiData;
  logic [WIDTH-1:0] wLoData;

  modport master (
    output start, md_op, regaData, regbData, cancel,
    input  busy, stall, done, whi, wlo, wHiData, wLoData
  );

  modport slave (
    input  start, md_op, regaData, regbData, cancel,
    output busy, stall, done, whi, wlo, wHiData, wLoData
  );

endinterface

// File: rtl/md_negate.sv
// Conditional two's-complement negation.
// Ports:
//   val_i : input value
//   en_i  : 1 = output -val_i, 0 = pass val_i through
//   val_o : result (same width, wraps for the most negative value)
module md_negate
  import md_seq_pkg::*;
#(
  parameter int W = 2 * MD_WIDTH
) (
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/md_seq.sv
// Multi-cycle multiply/divide sequencer.
// A radix-2 engine runs 32 shift-add (multiply) or restoring-divide steps
// on operand magnitudes, then a FIX cycle applies the result signs and
// loads the HI/LO result registers. DONE raises done/whi/wlo for one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : request/result bundle (slave side), see md_seq_if
module md_seq
  import md_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input logic   clk,
  input logic   rst,
  md_seq_if.slave bus
);

  localparam int               DW       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  md_state_e        state_q, state_d;
  // acc holds {HI,LO} for multiply and {rem,quot} for divide.
  logic [DW-1:0]    acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Request decode at capture time.
  logic             cap_div_s;
  logic             cap_signed_s;
  logic             cap_sign_a_s;
  logic             cap_sign_b_s;
  logic             cap_divzero_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;

  assign cap_div_s     = op_is_div(bus.md_op);
  assign cap_signed_s  = op_is_signed(bus.md_op);
  assign cap_sign_a_s  = cap_signed_s & bus.regaData[WIDTH-1];
  assign cap_sign_b_s  = cap_signed_s & bus.regbData[WIDTH-1];
  assign cap_divzero_s = cap_div_s & (bus.regbData == {WIDTH{1'b0}});

  md_negate #(.W(WIDTH)) u_mag_a (
    .val_i (bus.regaData),
    .en_i  (cap_sign_a_s),
    .val_o (mag_a_s)
  );

  md_negate #(.W(WIDTH)) u_mag_b (
    .val_i (bus.regbData),
    .en_i  (cap_sign_b_s),
    .val_o (mag_b_s)
  );

  // One iteration step of each engine.
  logic [WIDTH-1:0] acc_hi_s;
  logic [WIDTH-1:0] acc_lo_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [DW-1:0]    mul_next_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   div_diff_s;
  logic             div_take_s;
  logic [DW-1:0]    div_next_s;

  assign acc_hi_s = acc_q[DW-1:WIDTH];
  assign acc_lo_s = acc_q[WIDTH-1:0];

  // Add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right by one (carry enters the top).
  assign mul_sum_s  = {1'b0, acc_hi_s} +
                      (acc_lo_s[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_lo_s[WIDTH-1:1]};

  // Restoring divide: the shifted remainder can reach WIDTH+1 bits; when
  // its top bit is set it always exceeds the divisor, so no borrow occurs
  // and the low WIDTH bits of the difference are the true new remainder.
  assign rem_sh_s   = {acc_hi_s, acc_lo_s[WIDTH-1]};
  assign div_diff_s = {1'b0, rem_sh_s[WIDTH-1:0]} - {1'b0, opb_q};
  assign div_take_s = rem_sh_s[WIDTH] | ~div_diff_s[WIDTH];
  assign div_next_s = div_take_s ?
                      {div_diff_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1} :
                      {rem_sh_s[WIDTH-1:0],   acc_lo_s[WIDTH-2:0], 1'b0};

  // Sign fix-up of the finished magnitudes.
  logic [DW-1:0]    prod_fix_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  md_negate #(.W(DW)) u_fix_prod (
    .val_i (acc_q),
    .en_i  (~is_div_q & (sign_a_q ^ sign_b_q)),
    .val_o (prod_fix_s)
  );

  md_negate #(.W(WIDTH)) u_fix_quot (
    .val_i (acc_lo_s),
    .en_i  (is_div_q & (sign_a_q ^ sign_b_q)),
    .val_o (quot_fix_s)
  );

  // Remainder takes the sign of the dividend.
  md_negate #(.W(WIDTH)) u_fix_rem (
    .val_i (acc_hi_s),
    .en_i  (is_div_q & sign_a_q),
    .val_o (rem_fix_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= {DW{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sign_a_d = cap_sign_a_s;
          sign_b_d = cap_sign_b_s;
          is_div_d = cap_div_s;
          cnt_d    = {CNT_W{1'b0}};
          if (cap_div_s) begin
            acc_d = {{WIDTH{1'b0}}, mag_a_s};
            opb_d = mag_b_s;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag_b_s};
            opb_d = mag_a_s;
          end
          if (cap_divzero_s) begin
            // Divide by zero skips the engine: HI=raw A, LO=all ones.
            hi_d    = bus.regaData;
            lo_d    = {WIDTH{1'b1}};
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ITER: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next_s : mul_next_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_ITER;
          end
        end
      end

      S_FIX: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            hi_d = rem_fix_s;
            lo_d = quot_fix_s;
          end else begin
            hi_d = prod_fix_s[DW-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from state; stall also covers the accept cycle.
  logic accept_s;
  assign accept_s    = (state_q == S_IDLE) | (state_q == S_DONE);
  assign bus.busy    = ((state_q == S_ITER) | (state_q == S_FIX)) ? VALID : INVALID;
  assign bus.done    = (state_q == S_DONE) ? VALID : INVALID;
  assign bus.whi     = bus.done;
  assign bus.wlo     = bus.done;
  assign bus.stall   = rst & (bus.busy | (bus.start & accept_s));
  assign bus.wHiData = hi_q;
  assign bus.wLoData = lo_q;

endmodule

// File: tb/tb_md_seq.sv
module tb_md_seq;
  import md_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  md_seq_if #(.WIDTH(32)) bus ();

  md_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain 64-bit arithmetic from the operation definitions.
  function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq;
    logic [63:0]     r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    if (op[1] && b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op == 2'd0) begin
      r64 = 64'(sa * sb);
      hi = r64[63:32];
      lo = r64[31:0];
    end else if (op == 2'd1) begin
      r64 = 64'(ua * ub);
      hi = r64[63:32];
      lo = r64[31:0];
    end else if (op == 2'd2) begin
      sq = sa / sb;
      sr = sa % sb;
      r64 = 64'(sq);
      lo = r64[31:0];
      r64 = 64'(sr);
      hi = r64[31:0];
    end else begin
      uq = ua / ub;
      r64 = 64'(uq);
      lo = r64[31:0];
      r64 = 64'(ua % ub);
      hi = r64[31:0];
    end
  endfunction

  // Issue one request and wait for done; edges counts from the sampling edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic stall_ok, output logic we_ok,
                        output logic [31:0] hi, output logic [31:0] lo);
    logic found;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.regaData = a;
    bus.regbData = b;
    #1;
    stall_ok = (bus.stall === 1'b1);
    found = 1'b0;
    edges = -1;
    we_ok = 1'b0;
    hi = 32'd0;
    lo = 32'd0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        found = 1'b1;
        edges = i + 1;
        we_ok = (bus.whi === 1'b1) && (bus.wlo === 1'b1);
        hi = bus.wHiData;
        lo = bus.wLoData;
      end else if (bus.stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.md_op = 2'd0;
    bus.regaData = 32'd0;
    bus.regbData = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.stall, bus.done, bus.whi, bus.wlo} !== 5'b0) begin
      $display("FAIL reset_flags: got %b expected 00000", {bus.busy, bus.stall, bus.done, bus.whi, bus.wlo});
      miscompares++;
    end
    vectors++;
    if (bus.wHiData !== 32'd0 || bus.wLoData !== 32'd0) begin
      $display("FAIL reset_data: got %h/%h expected 0/0", bus.wHiData, bus.wLoData);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } dir_t;

  task automatic test_directed();
    dir_t tbl[7];
    int edges;
    logic stall_ok, we_ok;
    logic [31:0] hi, lo;
    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    tbl[1] = '{2'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    tbl[3] = '{2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
    tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1};
    tbl[6] = '{2'd3, 32'd1000,      32'd7,         32'd6,         32'd142,       34};
    foreach (tbl[k]) begin
      run_op(tbl[k].op, tbl[k].a, tbl[k].b, edges, stall_ok, we_ok, hi, lo);
      vectors++;
      if (edges != tbl[k].lat) begin
        $display("FAIL dir%0d_latency: got %0d expected %0d", k, edges, tbl[k].lat);
        miscompares++;
      end
      vectors++;
      if (hi !== tbl[k].hi || lo !== tbl[k].lo) begin
        $display("FAIL dir%0d_result: got %h/%h expected %h/%h", k, hi, lo, tbl[k].hi, tbl[k].lo);
        miscompares++;
      end
      vectors++;
      if (!(stall_ok && we_ok)) begin
        $display("FAIL dir%0d_stall_we: got stall_ok=%b we_ok=%b expected 1/1", k, stall_ok, we_ok);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (bus.done !== 1'b0) begin
        $display("FAIL dir%0d_done_width: got %b expected 0", k, bus.done);
        miscompares++;
      end
    end
  endtask

  task automatic test_random();
    int edges, exp_lat;
    logic stall_ok, we_ok;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo, ehi, elo;
    int sel;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else b = $urandom;
      ref_md(op, a, b, ehi, elo);
      exp_lat = (op[1] && b == 32'd0) ? 1 : 34;
      run_op(op, a, b, edges, stall_ok, we_ok, hi, lo);
      vectors++;
      if (edges != exp_lat || hi !== ehi || lo !== elo || !we_ok) begin
        $display("FAIL rand%0d op=%0d a=%h b=%h: got lat=%0d %h/%h we=%b expected lat=%0d %h/%h we=1",
                 n, op, a, b, edges, hi, lo, we_ok, exp_lat, ehi, elo);
        miscompares++;
      end
    end
  endtask

  task automatic test_cancel();
    int edges;
    logic stall_ok, we_ok, saw_done;
    logic [31:0] hi, lo;
    run_op(2'd1, 32'd2, 32'd3, edges, stall_ok, we_ok, hi, lo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'd3;
    bus.regaData = 32'd1000;
    bus.regbData = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
      $display("FAIL cancel_flags: got busy=%b done=%b stall=%b expected 0/0/0", bus.busy, bus.done, bus.stall);
      miscompares++;
    end
    vectors++;
    if (bus.wHiData !== 32'd0 || bus.wLoData !== 32'd6) begin
      $display("FAIL cancel_data: got %h/%h expected 00000000/00000006", bus.wHiData, bus.wLoData);
      miscompares++;
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      $display("FAIL cancel_quiet: got activity after cancel expected none");
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic found;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'd3;
    bus.regaData = 32'd1000;
    bus.regbData = 32'd7;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found || bus.wHiData !== 32'd6 || bus.wLoData !== 32'd142) begin
      $display("FAIL b2b_first: got done=%b %h/%h expected 1 00000006/0000008e", found, bus.wHiData, bus.wLoData);
      miscompares++;
    end
    bus.start = 1'b1;
    bus.md_op = 2'd1;
    bus.regaData = 32'd6;
    bus.regbData = 32'd7;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      $display("FAIL b2b_stall: got %b expected 1", bus.stall);
      miscompares++;
    end
    found = 1'b0;
    edges = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        found = 1'b1;
        edges = i + 1;
      end
    end
    vectors++;
    if (edges != 34 || bus.wHiData !== 32'd0 || bus.wLoData !== 32'd42) begin
      $display("FAIL b2b_second: got lat=%0d %h/%h expected lat=34 00000000/0000002a", edges, bus.wHiData, bus.wLoData);
      miscompares++;
    end
  endtask

  task automatic test_rst_mid();
    int edges;
    logic stall_ok, we_ok;
    logic [31:0] hi, lo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = 2'd1;
    bus.regaData = 32'h0001_2345;
    bus.regbData = 32'h0000_0777;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.stall, bus.done, bus.whi, bus.wlo} !== 5'b0) begin
      $display("FAIL rstmid_flags: got %b expected 00000", {bus.busy, bus.stall, bus.done, bus.whi, bus.wlo});
      miscompares++;
    end
    vectors++;
    if (bus.wHiData !== 32'd0 || bus.wLoData !== 32'd0) begin
      $display("FAIL rstmid_data: got %h/%h expected 0/0", bus.wHiData, bus.wLoData);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(2'd1, 32'd2, 32'd3, edges, stall_ok, we_ok, hi, lo);
    vectors++;
    if (edges != 34 || hi !== 32'd0 || lo !== 32'd6) begin
      $display("FAIL rstmid_after: got lat=%0d %h/%h expected lat=34 00000000/00000006", edges, hi, lo);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_back_to_back();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
